// File: rtl/pipe_hazard_scoreboard_if.sv
// Decode-side bundle of the hazard scoreboard: ID instruction fields, pipe
// control in, and the stall / forwarding / statistics results out.
interface pipe_hazard_scoreboard_if #(
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int SEL_W   = $clog2(DEPTH + 1)
);
  logic                      id_valid;
  logic                      id_wb_en;
  logic                      id_is_load;
  logic [REG_AW-1:0]         id_dest;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic                      flush;
  logic                      mem_busy;
  logic                      stall;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic [31:0]               stall_cnt;

  modport master (
    output id_valid, id_wb_en, id_is_load, id_dest, id_src, id_src_used,
    output flush, mem_busy,
    input  stall, fwd_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_wb_en, id_is_load, id_dest, id_src, id_src_used,
    input  flush, mem_busy,
    output stall, fwd_sel, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_scoreboard.sv
// Shift-register scoreboard of post-decode instructions (slot 0 = EXE) that
// produces per-source forwarding selects, a single stall and a stall counter.
module pipe_hazard_scoreboard #(
  parameter int REG_AW    = 4,
  parameter int DEPTH     = 3,
  parameter int NUM_SRC   = 2,
  parameter int FWD_EN    = 1,
  parameter int LOAD_SLOT = 1,
  parameter int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  pipe_hazard_scoreboard_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              is_load;
    logic [REG_AW-1:0] dest;
  } slot_t;

  slot_t              slots_q [DEPTH];
  slot_t              slots_d [DEPTH];
  logic [31:0]        stall_cnt_q;
  logic [31:0]        stall_cnt_d;
  logic [SEL_W-1:0]   hit_sel [NUM_SRC];
  logic [NUM_SRC-1:0] src_stall;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic               stall;

  // NOTE: every variable gets a default at the top of the block so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    fwd_sel   = '0;
    src_stall = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      hit_sel[s] = '0;
      // Scan oldest to youngest so the youngest match is the last one written.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (bus.id_valid && bus.id_src_used[s] && slots_q[k].valid &&
            slots_q[k].wb_en && slots_q[k].dest == bus.id_src[s*REG_AW +: REG_AW]) begin
          hit_sel[s]   = SEL_W'(k + 1);
          src_stall[s] = (FWD_EN == 0) || (slots_q[k].is_load && (k < LOAD_SLOT));
        end
      end
      if (FWD_EN != 0 && !src_stall[s]) begin
        fwd_sel[s*SEL_W +: SEL_W] = hit_sel[s];
      end
    end
    // A taken branch squashes the ID instruction, so its RAW hazard is moot.
    stall = bus.mem_busy | (~bus.flush & (|src_stall));
  end

  always_comb begin
    slots_d     = slots_q;
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (!bus.mem_busy) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        slots_d[k] = slots_q[k-1];
      end
      slots_d[0] = '0;
      if (bus.id_valid && !stall && !bus.flush) begin
        slots_d[0] = '{valid: 1'b1, wb_en: bus.id_wb_en,
                       is_load: bus.id_is_load, dest: bus.id_dest};
      end
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the slot array is reset explicitly; its valid bits gate every
      // match, so stale contents after reset would create phantom hazards.
      for (int k = 0; k < DEPTH; k++) begin
        slots_q[k] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      slots_q     <= slots_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.fwd_sel   = fwd_sel;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_scoreboard.md
Name: pipe_hazard_scoreboard

Overview:
Parametrised successor to the fixed two-source hazard and forwarding logic of the 5-stage core. It keeps a shift-register scoreboard of in-flight instructions after decode: slot 0 is EXE, slot 1 is MEM, slot DEPTH-1 is WB. Each cycle it produces, per decode source, a forwarding select and a single stall. It also supports a load-use latency, a memory-busy freeze, branch-flush bubble insertion and a saturating stall counter.

Parameters:
REG_AW, 4, register address width.
DEPTH, 3, number of tracked post-decode stages (minimum 2).
NUM_SRC, 2, number of source operands per decoded instruction.
FWD_EN, 1, 1 = forwarding enabled; 0 = stall on every RAW match.
LOAD_SLOT, 1, lowest slot index from which load data can be forwarded (0 < LOAD_SLOT < DEPTH).
SEL_W, $clog2(DEPTH+1), forwarding select width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
id_valid  in  1  a real instruction is in ID.
id_wb_en  in  1  the ID instruction writes a register.
id_is_load  in  1  the ID instruction is a load.
id_dest  in  REG_AW  ID destination register.
id_src  in  NUM_SRC*REG_AW  packed ID source registers; source s occupies bits [s*REG_AW +: REG_AW].
id_src_used  in  NUM_SRC  per-source "operand read" flags.
flush  in  1  branch taken, resolved in EXE.
mem_busy  in  1  memory stage not ready; whole pipe frozen.
stall  out  1  freeze PC and IF/ID, insert a bubble into ID/EXE.
fwd_sel  out  NUM_SRC*SEL_W  per source: 0 = register file, k+1 = value from slot k.
stall_cnt  out  32  saturating count of cycles with stall=1.

Behaviour:
- Slot entry fields: valid, wb_en, dest, is_load.
- Reset: all slots invalid, stall_cnt=0. fwd_sel and stall are combinational, so both read 0 in the cycle after reset.
- Match for source s at slot k: id_valid & id_src_used[s] & slot[k].valid & slot[k].wb_en & slot[k].dest==src_s.
- The youngest match wins (lowest k). fwd_sel[s]=k+1, or 0 if there is no match.
- Stall contribution of source s:
  - FWD_EN=1: stall when the youngest match has is_load=1 and k<LOAD_SLOT.
  - FWD_EN=0: stall on any match.
- stall = mem_busy | (~flush & OR of source contributions).
- fwd_sel is forced to 0 for any source whose contribution is stalling, and for all sources when FWD_EN=0.
- Sequential update, when mem_busy=1: all slots hold and flush is ignored. Upstream holds flush until mem_busy drops.
- Sequential update, when mem_busy=0:
  - slot[k+1] <= slot[k] for k=0..DEPTH-2; slot DEPTH-1 retires.
  - slot[0] <= the ID instruction when id_valid & ~stall & ~flush; otherwise slot[0] <= bubble (valid=0).
- flush and RAW stall in the same cycle: flush wins. stall=0 (unless mem_busy), a bubble is inserted, and the squashed ID instruction is never recorded.
- Load in slot k≥LOAD_SLOT: forwarded normally, no stall. With the defaults, a load-use pair gives exactly 1 stall cycle.
- stall_cnt increments on every cycle with stall=1 and saturates at 0xFFFF_FFFF.
- rst asserted mid-operation clears every slot on that edge regardless of mem_busy or flush.
- Destination register 15 is not treated specially; the producer side gates wb_en for it.
- Latency: outputs are combinational from current slots and ID inputs. The scoreboard advances one slot per unfrozen cycle.

Test Plan:
1. ALU RAW, defaults. ADD r1 then SUB r2,r1,r3 back-to-back -> during SUB in ID, fwd_sel[0]=1, stall=0. One cycle later, with a non-writing instruction in ID reading r1 -> fwd_sel=2.
2. Load-use. LDR r4 then ADD r5,r4,r4 -> stall=1 for exactly 1 cycle with a bubble in slot0; next cycle fwd_sel[0]=fwd_sel[1]=2, stall=0; stall_cnt=1.
3. FWD_EN=0 build. ALU r1 followed by a consumer of r1 -> stall=1 for DEPTH=3 cycles, then fwd_sel=0; stall_cnt=3.
4. Youngest-wins. Slot0 and slot1 both have dest r7, consumer reads r7 -> fwd_sel=1. Unused source (id_src_used=0) with a matching register -> fwd_sel=0, no stall.
5. Flush during load-use stall. LDR r4 in slot0, consumer in ID, flush=1 -> stall=0, slot0 becomes a bubble. Next cycle the load is in slot1 and no entry with dest r4 enters.
6. mem_busy held 4 cycles mid-stream -> stall=1 for all 4, slots unchanged, stall_cnt+=4. rst pulsed during a later freeze -> all slots invalid, stall_cnt=0, fwd_sel=0.
